// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
//
// Sequencer for the Sobel line-buffer datapath. Tracks the column/row position
// of the incoming VGA pixel stream, rotates three line buffers, drives the
// line-buffer write controls and delays the sync signals by the datapath
// latency. Output pixels whose 3x3 window is incomplete can be flagged.
//
// Optional feature macro: SOBEL_BORDER_MASK_EN
//   defined     : border_o flags incomplete-window pixels, win_valid_o excludes them
//   not defined : border_o tied to 0, win_valid_o = dv_o while a frame is active
//
// Parameters
//   MAX_WIDTH : maximum active pixels per line (AW = $clog2(MAX_WIDTH))
//   ROW_W     : row counter width
//   LATENCY   : dv_i sample to dv_o delay in cycles (1..16)
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   dv_i, hs_i, vs_i          : input pixel valid, hsync, vsync (active-high)
//   lb_we_o, lb_addr_o        : line-buffer write enable / address (combinational)
//   lb_wsel_o                 : buffer being written (0..2)
//   lb_rsel0_o, lb_rsel1_o    : buffers holding row-1 and row-2
//   dv_o, hs_o, vs_o          : inputs delayed by LATENCY
//   win_valid_o, border_o     : window status, aligned with dv_o
//   ovf_o                     : sticky line-overflow flag, cleared at frame start
// -----------------------------------------------------------------------------
module sobel_window_ctrl #(
    parameter int MAX_WIDTH = 1024,
    parameter int ROW_W     = 11,
    parameter int LATENCY   = 4,
    localparam int AW       = $clog2(MAX_WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dv_i,
    input  logic          hs_i,
    input  logic          vs_i,
    output logic          lb_we_o,
    output logic [AW-1:0] lb_addr_o,
    output logic [1:0]    lb_wsel_o,
    output logic [1:0]    lb_rsel0_o,
    output logic [1:0]    lb_rsel1_o,
    output logic          dv_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          win_valid_o,
    output logic          border_o,
    output logic          ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] ROW_MAX = '1;
    localparam logic [AW-1:0]    COL_MAX = AW'(MAX_WIDTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [1:0]        wsel_q, wsel_d;
    logic [1:0]        rsel0_q, rsel0_d;
    logic [1:0]        rsel1_q, rsel1_d;
    logic              ovf_q, ovf_d;
    logic              vs_q;
    logic              dv_q;

    // Pipeline element: {window flag, vs, hs, dv}
    logic [3:0]        pipe_q [LATENCY];
    logic [3:0]        pipe_d [LATENCY];

    logic              frame_start;
    logic              line_end;
    logic              idle_eff;
    logic [AW-1:0]     col_eff;
    logic [ROW_W-1:0]  row_eff;
    logic              sat;
    logic              win_flag;

    // A frame start takes effect in the cycle it is seen, so a pixel arriving
    // together with the vs_i rise is already row 0 / col 0 of the new frame.
    always_comb begin
        frame_start = vs_i & ~vs_q & ~rst;
        line_end    = dv_q & ~dv_i;
        idle_eff    = (state_q == ST_IDLE) & ~frame_start;
        col_eff     = frame_start ? '0 : col_q;
        row_eff     = frame_start ? '0 : row_q;
        sat         = (col_eff == COL_MAX);

        lb_we_o     = dv_i & ~idle_eff & ~sat & ~rst;
        lb_addr_o   = col_eff;
        // Force buffer 0 for the pixel that coincides with frame start.
        lb_wsel_o   = frame_start ? 2'd0 : wsel_q;
        lb_rsel0_o  = rsel0_q;
        lb_rsel1_o  = rsel1_q;

`ifdef SOBEL_BORDER_MASK_EN
        win_flag    = idle_eff | (row_eff < ROW_W'(2)) | (col_eff < AW'(2));
`else
        win_flag    = ~idle_eff;
`endif
    end

    // Next-state for position counters, buffer rotation and FSM
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wsel_d  = wsel_q;
        ovf_d   = ovf_q;

        if (frame_start) begin
            state_d = ST_FILL;
            row_d   = '0;
            wsel_d  = 2'd0;
            ovf_d   = 1'b0;
            col_d   = dv_i ? AW'(1) : '0;
        end else begin
            if (line_end) begin
                col_d  = '0;
                row_d  = (row_q == ROW_MAX) ? row_q : row_q + ROW_W'(1);
                wsel_d = (wsel_q == 2'd2) ? 2'd0 : wsel_q + 2'd1;
                if (state_q == ST_FILL && row_q == ROW_W'(1)) begin
                    state_d = ST_RUN;
                end
            end else if (dv_i && !sat) begin
                col_d = col_q + AW'(1);
            end
            if (dv_i && sat) begin
                ovf_d = 1'b1;
            end
        end

        // Read selects trail the write select: row-1 and row-2 buffers
        case (wsel_d)
            2'd0:    begin rsel0_d = 2'd2; rsel1_d = 2'd1; end
            2'd1:    begin rsel0_d = 2'd0; rsel1_d = 2'd2; end
            default: begin rsel0_d = 2'd1; rsel1_d = 2'd0; end
        endcase
    end

    always_comb begin
        pipe_d[0] = {win_flag, vs_i, hs_i, dv_i};
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Edge-detect copies follow their inputs even in reset so that a sync
    // already high when reset is released is not mistaken for a new edge.
    always_ff @(posedge clk) begin
        vs_q <= vs_i;
        dv_q <= dv_i;
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wsel_q  <= 2'd0;
            rsel0_q <= 2'd2;
            rsel1_q <= 2'd1;
            ovf_q   <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wsel_q  <= wsel_d;
            rsel0_q <= rsel0_d;
            rsel1_q <= rsel1_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Delayed outputs
    always_comb begin
        dv_o  = pipe_q[LATENCY-1][0];
        hs_o  = pipe_q[LATENCY-1][1];
        vs_o  = pipe_q[LATENCY-1][2];
        ovf_o = ovf_q;
`ifdef SOBEL_BORDER_MASK_EN
        border_o    = dv_o & pipe_q[LATENCY-1][3];
        win_valid_o = dv_o & ~border_o;
`else
        border_o    = 1'b0;
        win_valid_o = dv_o & pipe_q[LATENCY-1][3];
`endif
    end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_ctrl
//
// Scoreboard bench for sobel_window_ctrl (MAX_WIDTH=16, LATENCY=4). The driver
// issues directed frames and pushes the expected window status of every pixel;
// a monitor on the falling edge pops it whenever dv_o is high and also checks
// dv/hs/vs against its own LATENCY-deep history of the inputs.
// -----------------------------------------------------------------------------
module tb_sobel_window_ctrl;

    localparam int MAXW  = 16;
    localparam int LAT   = 4;
    localparam int ROW_W = 11;
    localparam int AW    = $clog2(MAXW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dv_i = 1'b0;
    logic          hs_i = 1'b0;
    logic          vs_i = 1'b0;
    logic          lb_we_o;
    logic [AW-1:0] lb_addr_o;
    logic [1:0]    lb_wsel_o;
    logic [1:0]    lb_rsel0_o;
    logic [1:0]    lb_rsel1_o;
    logic          dv_o;
    logic          hs_o;
    logic          vs_o;
    logic          win_valid_o;
    logic          border_o;
    logic          ovf_o;

    always #5 clk = ~clk;

    sobel_window_ctrl #(
        .MAX_WIDTH (MAXW),
        .ROW_W     (ROW_W),
        .LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dv_i        (dv_i),
        .hs_i        (hs_i),
        .vs_i        (vs_i),
        .lb_we_o     (lb_we_o),
        .lb_addr_o   (lb_addr_o),
        .lb_wsel_o   (lb_wsel_o),
        .lb_rsel0_o  (lb_rsel0_o),
        .lb_rsel1_o  (lb_rsel1_o),
        .dv_o        (dv_o),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .win_valid_o (win_valid_o),
        .border_o    (border_o),
        .ovf_o       (ovf_o)
    );

    typedef struct packed {
        logic win;
        logic border;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   frame_active = 1'b0;
    bit   done = 1'b0;
    logic [2:0] hist [LAT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void push_px(input int row, input int col, input bit active);
        exp_t e;
`ifdef SOBEL_BORDER_MASK_EN
        e.border = !active || row < 2 || col < 2;
        e.win    = !e.border;
`else
        e.border = 1'b0;
        e.win    = active;
`endif
        sb.push_back(e);
    endfunction

    task automatic drive(input logic d, input logic h, input logic v);
        @(posedge clk);
        #1;
        dv_i = d;
        hs_i = h;
        vs_i = v;
    endtask

    // One pixel; with_vs raises vs_i in the same cycle
    task automatic pixel(input int row, input int col, input bit with_vs);
        drive(1'b1, 1'b0, with_vs);
        if (with_vs) frame_active = 1'b1;
        #1;
        chk("lb_we", lb_we_o, (frame_active && col < MAXW - 1));
        if (frame_active) begin
            chk("lb_addr", lb_addr_o, (col < MAXW - 1) ? col : MAXW - 1);
            chk("ovf", ovf_o, col >= MAXW);
        end
        push_px(row, col, frame_active);
    endtask

    task automatic line(input int row, input int cols, input bit with_vs);
        for (int c = 0; c < cols; c++) begin
            pixel(row, c, with_vs && c == 0);
            if (c == 0 && frame_active) begin
                chk("lb_wsel", lb_wsel_o, row % 3);
                if (!with_vs) begin
                    chk("lb_rsel0", lb_rsel0_o, (row + 2) % 3);
                    chk("lb_rsel1", lb_rsel1_o, (row + 1) % 3);
                end
            end
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int rows, input int cols, input bit vs_with_dv);
        if (!vs_with_dv) begin
            drive(1'b0, 1'b0, 1'b1);
            frame_active = 1'b1;
            drive(1'b0, 1'b0, 1'b0);
        end
        for (int r = 0; r < rows; r++) begin
            line(r, cols, vs_with_dv && r == 0);
        end
    endtask

    // Monitor: sync-delay reference and window-status scoreboard
    initial begin
        for (int i = 0; i < LAT; i++) hist[i] = '0;
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            chk("dv_o", dv_o, hist[LAT-1][0]);
            chk("hs_o", hs_o, hist[LAT-1][1]);
            chk("vs_o", vs_o, hist[LAT-1][2]);
            if (dv_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("dv_o_unexpected", dv_o, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("win_valid", win_valid_o, e.win);
                    chk("border", border_o, e.border);
                end
            end else begin
                chk("win_valid_idle", win_valid_o, 0);
                chk("border_idle", border_o, 0);
            end
            if (rst) begin
                sb.delete();
                for (int i = 0; i < LAT; i++) hist[i] = '0;
            end else begin
                for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = {vs_i, hs_i, dv_i};
            end
        end
    end

    // Driver
    initial begin
        // Reset hold with active sync/dv
        for (int i = 0; i < 10; i++) begin
            drive(i[0], (i % 3) == 0, (i % 4) < 2);
            #1;
            chk("rst_we", lb_we_o, 0);
            chk("rst_addr", lb_addr_o, 0);
            chk("rst_wsel", lb_wsel_o, 0);
            chk("rst_rsel0", lb_rsel0_o, 2);
            chk("rst_rsel1", lb_rsel1_o, 1);
            chk("rst_ovf", ovf_o, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // Small 8x4 frame
        frame(4, 8, 1'b0);

        // Frame start coinciding with the first pixel
        frame(4, 8, 1'b1);

        // Reset in the middle of row 2
        drive(1'b0, 1'b0, 1'b1);
        frame_active = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        line(0, 8, 1'b0);
        line(1, 8, 1'b0);
        for (int c = 0; c < 3; c++) pixel(2, c, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b1; dv_i = 1'b1; hs_i = 1'b0; vs_i = 1'b0;
            frame_active = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_we", lb_we_o, 0);
        push_px(2, 5, 1'b0);
        for (int c = 6; c < 8; c++) pixel(2, c, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        line(3, 8, 1'b0);
        frame(4, 8, 1'b0);

        // Overflow: one 20-pixel line
        frame(1, 20, 1'b0);
        #1;
        chk("ovf_sticky", ovf_o, 1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        #1;
        chk("ovf_cleared", ovf_o, 0);
        frame(4, 8, 1'b0);

        repeat (8) drive(1'b0, 1'b0, 1'b0);
        done = 1'b1;
        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
